// File: rtl/keypad_entry_ctrl.sv
// keypad_entry_ctrl
// Sequences the decimal-to-BCD keypad encoder for the microwave front panel.
// It debounces the encoder loadn strobe and shifts each accepted BCD digit
// into an MM:SS entry register (digit 0 = seconds ones).
// Entry is frozen while cooking (lock) and cleared by cancel.
// Optional build macro SEC_CLAMP_EN: the seconds field of time_bcd is shown
// as 59 whenever the raw seconds value exceeds 59. The internal register
// still keeps the raw digits.
module keypad_entry_ctrl #(
    parameter int DIGITS       = 4,
    parameter int DEBOUNCE_CYC = 4
) (
    input  logic                         clk,
    input  logic                         clearn,
    input  logic [3:0]                   key_bcd,
    input  logic                         key_loadn,
    input  logic                         lock,
    input  logic                         cancel,
    output logic                         enc_enable,
    output logic [4*DIGITS-1:0]          time_bcd,
    output logic [$clog2(DIGITS+1)-1:0]  digit_count,
    output logic                         key_accept,
    output logic                         entry_full
);

    localparam int CNT_W = $clog2(DIGITS + 1);
    localparam int DB_W  = $clog2(DEBOUNCE_CYC + 1);

    typedef enum logic [2:0] {
        IDLE,
        PRESS,
        ACCEPT,
        RELEASE,
        LOCKED
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [DB_W-1:0]     deb_cnt;
    logic [DB_W-1:0]     deb_next;
    logic [DB_W-1:0]     deb_inc;
    logic                do_shift;
    logic                do_clear;
    logic                enable_next;
    logic [4*DIGITS-1:0] time_raw;

    assign deb_inc    = deb_cnt + DB_W'(1);
    assign entry_full = (digit_count == CNT_W'(DIGITS));

    // State register and debounce counter
    always_ff @(posedge clk or negedge clearn) begin
        if (!clearn) begin
            state   <= IDLE;
            deb_cnt <= '0;
        end else begin
            state   <= state_next;
            deb_cnt <= deb_next;
        end
    end

    // Next-state logic; lock overrides everything and cancel overrides a pending accept
    always_comb begin
        state_next = state;
        deb_next   = deb_cnt;
        do_shift   = 1'b0;
        do_clear   = cancel;

        case (state)
            IDLE: begin
                if (!key_loadn) begin
                    if (DEBOUNCE_CYC == 1) begin
                        state_next = ACCEPT;
                        deb_next   = '0;
                    end else begin
                        state_next = PRESS;
                        deb_next   = DB_W'(1);
                    end
                end
            end
            PRESS: begin
                if (key_loadn) begin
                    state_next = IDLE;
                    deb_next   = '0;
                end else if (deb_inc == DB_W'(DEBOUNCE_CYC)) begin
                    state_next = ACCEPT;
                    deb_next   = '0;
                end else begin
                    deb_next = deb_inc;
                end
            end
            ACCEPT: begin
                if ((key_bcd <= 4'd9) && !entry_full) begin
                    do_shift = 1'b1;
                end
                state_next = RELEASE;
                deb_next   = '0;
            end
            RELEASE: begin
                if (!key_loadn) begin
                    deb_next = '0;
                end else if (deb_inc == DB_W'(DEBOUNCE_CYC)) begin
                    state_next = IDLE;
                    deb_next   = '0;
                end else begin
                    deb_next = deb_inc;
                end
            end
            LOCKED: begin
                if (!lock) begin
                    state_next = RELEASE;
                    deb_next   = '0;
                end
            end
            default: begin
                state_next = IDLE;
                deb_next   = '0;
            end
        endcase

        if (cancel) begin
            state_next = IDLE;
            deb_next   = '0;
            do_shift   = 1'b0;
        end

        if (lock) begin
            state_next = LOCKED;
            deb_next   = '0;
            do_shift   = 1'b0;
        end

        enable_next = !lock && (state_next != LOCKED);
    end

    // Entry register, digit counter, accept pulse and registered encoder enable
    always_ff @(posedge clk or negedge clearn) begin
        if (!clearn) begin
            time_raw    <= '0;
            digit_count <= '0;
            key_accept  <= 1'b0;
            enc_enable  <= 1'b0;
        end else begin
            key_accept <= do_shift;
            enc_enable <= enable_next;
            if (do_clear) begin
                time_raw    <= '0;
                digit_count <= '0;
            end else if (do_shift) begin
                time_raw    <= {time_raw[4*DIGITS-5:0], key_bcd};
                digit_count <= digit_count + CNT_W'(1);
            end
        end
    end

`ifdef SEC_CLAMP_EN
    // Present the seconds field as 59 when the raw tens-of-seconds digit is 6 or more
    always_comb begin
        time_bcd = time_raw;
        if (time_raw[7:4] > 4'd5) begin
            time_bcd[7:0] = 8'h59;
        end
    end
`else
    assign time_bcd = time_raw;
`endif

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// tb_keypad_entry_ctrl
// Self-checking bench for keypad_entry_ctrl (DIGITS=4, DEBOUNCE_CYC=4).
// It runs directed sequences, a segment table and a randomized run.
// Every cycle is also checked against a digit-queue reference model.
module tb_keypad_entry_ctrl;

    localparam int DIGITS = 4;
    localparam int DEB    = 4;

    logic        clk = 1'b0;
    logic        clearn;
    logic [3:0]  key_bcd;
    logic        key_loadn;
    logic        lock;
    logic        cancel;
    logic        enc_enable;
    logic [15:0] time_bcd;
    logic [2:0]  digit_count;
    logic        key_accept;
    logic        entry_full;

    int n_cmp = 0;
    int n_bad = 0;
    int acc_seen = 0;

    always #5 clk = ~clk;

    keypad_entry_ctrl #(.DIGITS(DIGITS), .DEBOUNCE_CYC(DEB)) dut (
        .clk         (clk),
        .clearn      (clearn),
        .key_bcd     (key_bcd),
        .key_loadn   (key_loadn),
        .lock        (lock),
        .cancel      (cancel),
        .enc_enable  (enc_enable),
        .time_bcd    (time_bcd),
        .digit_count (digit_count),
        .key_accept  (key_accept),
        .entry_full  (entry_full)
    );

    // Reference model: accepted digits kept in a queue, newest last
    int q[$];
    bit m_locked, m_pending, m_releasing, m_acc, m_en;
    int m_low, m_high;

    function automatic logic [15:0] model_time();
        logic [15:0] t;
        t = '0;
        for (int i = 0; i < q.size(); i++) t[4*i +: 4] = 4'(q[q.size()-1-i]);
`ifdef SEC_CLAMP_EN
        if (t[7:4] > 4'd5) t[7:0] = 8'h59;
`endif
        return t;
    endfunction

    task automatic model_reset();
        q.delete();
        m_locked = 0; m_pending = 0; m_releasing = 0;
        m_low = 0; m_high = 0; m_acc = 0; m_en = 0;
    endtask

    task automatic model_step();
        bit take;
        take = 0;
        if (lock) begin
            m_locked = 1; m_pending = 0; m_releasing = 0; m_low = 0; m_high = 0;
        end else if (cancel) begin
            m_locked = 0; m_pending = 0; m_releasing = 0; m_low = 0; m_high = 0;
        end else if (m_locked) begin
            m_locked = 0; m_releasing = 1; m_high = 0;
        end else if (m_pending) begin
            m_pending = 0; take = 1; m_releasing = 1; m_high = 0;
        end else if (m_releasing) begin
            if (key_loadn) begin
                m_high++;
                if (m_high >= DEB) begin m_releasing = 0; m_high = 0; end
            end else begin
                m_high = 0;
            end
        end else begin
            if (!key_loadn) begin
                m_low++;
                if (m_low >= DEB) begin m_pending = 1; m_low = 0; end
            end else begin
                m_low = 0;
            end
        end
        m_acc = 0;
        if (cancel) begin
            q.delete();
        end else if (take && key_bcd <= 4'd9 && q.size() < DIGITS) begin
            q.push_back(int'(key_bcd));
            m_acc = 1;
        end
        m_en = !lock;
    endtask

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_model();
        check_output("model_time_bcd", 32'(time_bcd), 32'(model_time()));
        check_output("model_digit_count", 32'(digit_count), 32'(q.size()));
        check_output("model_key_accept", 32'(key_accept), 32'(m_acc));
        check_output("model_entry_full", 32'(entry_full), 32'(q.size() == DIGITS));
        check_output("model_enc_enable", 32'(enc_enable), 32'(m_en));
    endtask

    // One clock: inputs held from a negedge, model stepped at posedge, checked at next negedge
    task automatic apply_stimulus(input logic ld, input logic [3:0] k, input logic lk, input logic cn);
        key_loadn = ld; key_bcd = k; lock = lk; cancel = cn;
        @(posedge clk);
        model_step();
        @(negedge clk);
        if (key_accept) acc_seen++;
        check_model();
    endtask

    task automatic do_reset();
        clearn = 1'b0; key_loadn = 1'b1; key_bcd = 4'h0; lock = 1'b0; cancel = 1'b0;
        model_reset();
        #1;
        check_output("reset_time_bcd", 32'(time_bcd), 32'h0);
        check_output("reset_digit_count", 32'(digit_count), 32'h0);
        check_output("reset_enc_enable", 32'(enc_enable), 32'h0);
        @(negedge clk);
        @(negedge clk);
        clearn = 1'b1;
    endtask

    task automatic hold(input logic ld, input logic [3:0] k, input int n);
        for (int i = 0; i < n; i++) apply_stimulus(ld, k, 1'b0, 1'b0);
    endtask

    typedef struct {
        logic        loadn;
        logic [3:0]  key;
        logic        lock;
        logic        cancel;
        int          cycles;
        logic [15:0] exp_time;
        int          exp_count;
        int          exp_acc;
        logic        exp_en;
    } seg_t;

    seg_t tbl[20];

    initial begin
        int first;
        logic [15:0] exp99;
        logic lk;

        tbl[0]  = '{1'b0, 4'h4, 1'b0, 1'b0, 10, 16'h0004, 1, 1, 1'b1};
        tbl[1]  = '{1'b1, 4'h4, 1'b0, 1'b0,  6, 16'h0004, 1, 0, 1'b1};
        tbl[2]  = '{1'b0, 4'h1, 1'b0, 1'b0, 10, 16'h0041, 2, 1, 1'b1};
        tbl[3]  = '{1'b1, 4'h1, 1'b0, 1'b0,  6, 16'h0041, 2, 0, 1'b1};
        tbl[4]  = '{1'b0, 4'h7, 1'b0, 1'b0,  2, 16'h0041, 2, 0, 1'b1};
        tbl[5]  = '{1'b1, 4'h7, 1'b0, 1'b0,  3, 16'h0041, 2, 0, 1'b1};
        tbl[6]  = '{1'b0, 4'h3, 1'b0, 1'b0, 10, 16'h0413, 3, 1, 1'b1};
        tbl[7]  = '{1'b1, 4'h3, 1'b0, 1'b0,  6, 16'h0413, 3, 0, 1'b1};
        tbl[8]  = '{1'b0, 4'h0, 1'b0, 1'b0, 10, 16'h4130, 4, 1, 1'b1};
        tbl[9]  = '{1'b1, 4'h0, 1'b0, 1'b0,  6, 16'h4130, 4, 0, 1'b1};
        tbl[10] = '{1'b0, 4'h5, 1'b0, 1'b0, 10, 16'h4130, 4, 0, 1'b1};
        tbl[11] = '{1'b1, 4'h5, 1'b0, 1'b0,  6, 16'h4130, 4, 0, 1'b1};
        tbl[12] = '{1'b1, 4'h0, 1'b0, 1'b1,  1, 16'h0000, 0, 0, 1'b1};
        tbl[13] = '{1'b0, 4'hA, 1'b0, 1'b0, 10, 16'h0000, 0, 0, 1'b1};
        tbl[14] = '{1'b1, 4'hA, 1'b0, 1'b0,  6, 16'h0000, 0, 0, 1'b1};
        tbl[15] = '{1'b0, 4'h2, 1'b0, 1'b0, 10, 16'h0002, 1, 1, 1'b1};
        tbl[16] = '{1'b1, 4'h2, 1'b0, 1'b0,  6, 16'h0002, 1, 0, 1'b1};
        tbl[17] = '{1'b0, 4'h6, 1'b1, 1'b0, 10, 16'h0002, 1, 0, 1'b0};
        tbl[18] = '{1'b0, 4'h6, 1'b0, 1'b0, 10, 16'h0002, 1, 0, 1'b1};
        tbl[19] = '{1'b1, 4'h6, 1'b0, 1'b0,  6, 16'h0002, 1, 0, 1'b1};

        @(negedge clk);
        do_reset();

        // Press 4: accept pulse exactly at cycle 5 of the press
        first = 0;
        acc_seen = 0;
        for (int c = 1; c <= 10; c++) begin
            apply_stimulus(1'b0, 4'h4, 1'b0, 1'b0);
            if (key_accept && first == 0) first = c;
        end
        check_output("t1_accept_cycle", 32'(first), 32'd5);
        check_output("t1_accept_count", 32'(acc_seen), 32'd1);
        check_output("t1_time_bcd", 32'(time_bcd), 32'h0004);
        check_output("t1_digit_count", 32'(digit_count), 32'd1);
        hold(1'b1, 4'h4, 6);

        // Cancel during the ACCEPT cycle of key 7
        acc_seen = 0;
        hold(1'b0, 4'h7, DEB);
        apply_stimulus(1'b0, 4'h7, 1'b0, 1'b1);
        check_output("t4_cancel_accept", 32'(key_accept), 32'h0);
        check_output("t4_cancel_time", 32'(time_bcd), 32'h0);
        check_output("t4_cancel_count", 32'(digit_count), 32'h0);
        hold(1'b1, 4'h7, 6);
        check_output("t4_cancel_no_pulse", 32'(acc_seen), 32'h0);
        apply_stimulus(1'b0, 4'h6, 1'b1, 1'b0);
        check_output("t4_lock_enable", 32'(enc_enable), 32'h0);
        for (int i = 0; i < 9; i++) apply_stimulus(1'b0, 4'h6, 1'b1, 1'b0);
        check_output("t4_lock_ignored", 32'(acc_seen), 32'h0);
        apply_stimulus(1'b1, 4'h6, 1'b0, 1'b0);
        check_output("t4_unlock_enable", 32'(enc_enable), 32'h1);
        hold(1'b1, 4'h6, 5);

        // Keys 9,9: seconds clamp when enabled
        do_reset();
        hold(1'b0, 4'h9, 10); hold(1'b1, 4'h9, 6);
        hold(1'b0, 4'h9, 10); hold(1'b1, 4'h9, 6);
`ifdef SEC_CLAMP_EN
        exp99 = 16'h0059;
`else
        exp99 = 16'h0099;
`endif
        check_output("t5_time_bcd_99", 32'(time_bcd), 32'(exp99));
        check_output("t5_digit_count", 32'(digit_count), 32'd2);

        // Asynchronous reset in the middle of RELEASE, then an invalid code
        do_reset();
        hold(1'b0, 4'h4, 10);
        hold(1'b1, 4'h4, 2);
        #2 clearn = 1'b0;
        model_reset();
        #1;
        check_output("t6_async_time", 32'(time_bcd), 32'h0);
        check_output("t6_async_count", 32'(digit_count), 32'h0);
        check_output("t6_async_accept", 32'(key_accept), 32'h0);
        check_output("t6_async_full", 32'(entry_full), 32'h0);
        check_output("t6_async_enable", 32'(enc_enable), 32'h0);
        @(negedge clk);
        clearn = 1'b1;
        acc_seen = 0;
        hold(1'b0, 4'hA, 10); hold(1'b1, 4'hA, 6);
        check_output("t6_invalid_no_accept", 32'(acc_seen), 32'h0);
        check_output("t6_invalid_count", 32'(digit_count), 32'h0);

        // Segment table
        do_reset();
        for (int s = 0; s < 20; s++) begin
            acc_seen = 0;
            for (int c = 0; c < tbl[s].cycles; c++)
                apply_stimulus(tbl[s].loadn, tbl[s].key, tbl[s].lock, tbl[s].cancel);
            check_output($sformatf("seg%0d_time_bcd", s), 32'(time_bcd), 32'(tbl[s].exp_time));
            check_output($sformatf("seg%0d_digit_count", s), 32'(digit_count), 32'(tbl[s].exp_count));
            check_output($sformatf("seg%0d_accepts", s), 32'(acc_seen), 32'(tbl[s].exp_acc));
            check_output($sformatf("seg%0d_entry_full", s), 32'(entry_full), 32'(tbl[s].exp_count == DIGITS));
            check_output($sformatf("seg%0d_enc_enable", s), 32'(enc_enable), 32'(tbl[s].exp_en));
        end

        // Randomized runs against the reference model
        do_reset();
        lk = 1'b0;
        for (int r = 0; r < 300; r++) begin
            logic       lv;
            logic [3:0] kv;
            int         len;
            lv  = 1'($urandom_range(0, 1));
            kv  = 4'($urandom_range(0, 11));
            len = $urandom_range(1, 8);
            if ($urandom_range(0, 11) == 0) lk = ~lk;
            for (int c = 0; c < len; c++)
                apply_stimulus(lv, kv, lk, 1'($urandom_range(0, 24) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
